teclado_control: RTL
====================

Name: teclado_control

Overview:
- Sequencing controller downstream of the keyboard front end (PS/2 receiver plus key decoder).
- Consumes one-cycle key pulses (c, t, p, enter, arrows) and runs a three-field edit session for clock time, date or timer.
- Gates the PS/2 receiver through rx_en.
- Emits a one-cycle write strobe with the edited values to the RTC-side register bank.

Parameters:
- TIMEOUT_CYCLES, 32'd1_000_000_000: idle cycles before an edit session is abandoned (used only with TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- c  in  1  one-cycle pulse: start clock-time edit
- t  in  1  one-cycle pulse: start timer edit
- p  in  1  one-cycle pulse: start date edit
- enter  in  1  one-cycle pulse: commit
- arriba  in  1  one-cycle pulse: increment selected field
- abajo  in  1  one-cycle pulse: decrement selected field
- izquierda  in  1  one-cycle pulse: cursor left
- derecha  in  1  one-cycle pulse: cursor right
- actual0, actual1, actual2  in  8 each  current values of the target fields (hh/mm/ss or dd/mm/aa), binary
- rx_en  out  1  enable to the PS/2 receiver
- modo  out  2  0 idle, 1 hora, 2 fecha, 3 timer
- cursor  out  2  selected field, 0..2
- campo0, campo1, campo2  out  8 each  edit values, binary
- wr  out  1  one-cycle commit strobe
- wr_modo  out  2  mode being committed; valid with wr

Behaviour:
- Clock and reset:
  - Clock port is clk.
  - Reset port is reset: asynchronous, active-low (asserted when 0).
- Reset state: state IDLE; modo=0, cursor=0, campo0..2=0, wr=0, wr_modo=0, rx_en=1, timeout counter=0.
- States: IDLE, EDIT, COMMIT.
- IDLE:
  - On c, t or p: latch the mode (hora, timer or fecha), load campo0..2 from actual0..2, set cursor=0, go to EDIT next cycle.
  - Priority when pulses coincide: c > t > p.
  - enter and arrows are ignored.
- Load range check: a loaded value outside the field range is replaced by the field minimum.
- Field ranges:
  - hora and timer: campo0 0..23, campo1 0..59, campo2 0..59.
  - fecha: campo0 1..31, campo1 1..12, campo2 0..99.
- EDIT:
  - One action per cycle. Priority: enter > arriba > abajo > izquierda > derecha; lower-priority pulses in the same cycle are dropped.
  - c, t and p are ignored.
  - arriba: selected field +1; max wraps to min.
  - abajo: selected field −1; min wraps to max.
  - derecha: cursor +1, 2 wraps to 0.
  - izquierda: cursor −1, 0 wraps to 2.
  - enter: go to COMMIT.
- COMMIT (exactly one cycle):
  - wr=1, wr_modo=modo; campo0..2 hold the committed values.
  - rx_en=0 for this cycle only.
  - Next cycle: IDLE, modo=0, cursor=0. campo registers hold their last values.
- Latency: key pulse to updated campo/cursor = 1 cycle. enter to wr = 1 cycle.
- rx_en=1 in every state except COMMIT.
- Reset mid-session: immediate return to the reset state; no wr is emitted.
- Arithmetic: 8-bit unsigned; compare against the range before add/subtract so no overflow is visible.

Optional Feature:
- Macro: TECLADO_TIMEOUT_EN.
- When defined:
  - A 32-bit counter runs in EDIT and clears on any accepted key pulse.
  - When the counter reaches TIMEOUT_CYCLES−1, go to IDLE with no wr, modo=0, cursor=0.
- When not defined: the counter and timeout logic are absent, and EDIT persists until enter or reset.

Decomposition:
- Package teclado_pkg holds:
  - state encodings IDLE/EDIT/COMMIT;
  - modo codes MODO_IDLE/HORA/FECHA/TIMER;
  - per-mode field min/max constants.
- Sub-module campo_wrap: one 8-bit field register with inc/dec/load, min/max inputs and wrap. Instantiated 3 times.

Test Plan:
- Reset low mid-EDIT after c with campo1=30 → modo=0, cursor=0, campo0..2=0, wr never asserts, rx_en=1.
- actual=23,59,58; pulse c, derecha×2, arriba×2, enter → wr one cycle with wr_modo=1, campo=23,59,0; rx_en=0 that cycle only.
- p with actual=31,0,99 → campo=31,1,99 (0 clamped to min 1). abajo on cursor 0 ×31 → campo0 wraps 31→1→31.
- izquierda at cursor 0 → cursor=2; derecha at cursor 2 → cursor=0.
- Same-cycle enter+arriba in EDIT → COMMIT, field unchanged. Same-cycle c+t in IDLE → modo=1.
- With TECLADO_TIMEOUT_EN and TIMEOUT_CYCLES=16: t, then 16 idle cycles → modo=0, no wr. A key pulse at cycle 10 restarts the count.

Source files
------------

// File: rtl/teclado_pkg.sv
// Shared encodings for the keyboard edit controller: FSM states, mode codes
// and per-mode field limits.
package teclado_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic [1:0] MODO_IDLE  = 2'd0;
  localparam logic [1:0] MODO_HORA  = 2'd1;
  localparam logic [1:0] MODO_FECHA = 2'd2;
  localparam logic [1:0] MODO_TIMER = 2'd3;

  localparam logic [7:0] HT_MIN0 = 8'd0, HT_MAX0 = 8'd23;
  localparam logic [7:0] HT_MIN1 = 8'd0, HT_MAX1 = 8'd59;
  localparam logic [7:0] HT_MIN2 = 8'd0, HT_MAX2 = 8'd59;
  localparam logic [7:0] FE_MIN0 = 8'd1, FE_MAX0 = 8'd31;
  localparam logic [7:0] FE_MIN1 = 8'd1, FE_MAX1 = 8'd12;
  localparam logic [7:0] FE_MIN2 = 8'd0, FE_MAX2 = 8'd99;

  function automatic logic [7:0] fld_min(logic [1:0] m, logic [1:0] idx);
    if (m == MODO_FECHA)
      return (idx == 2'd0) ? FE_MIN0 : (idx == 2'd1) ? FE_MIN1 : FE_MIN2;
    return (idx == 2'd0) ? HT_MIN0 : (idx == 2'd1) ? HT_MIN1 : HT_MIN2;
  endfunction

  function automatic logic [7:0] fld_max(logic [1:0] m, logic [1:0] idx);
    if (m == MODO_FECHA)
      return (idx == 2'd0) ? FE_MAX0 : (idx == 2'd1) ? FE_MAX1 : FE_MAX2;
    return (idx == 2'd0) ? HT_MAX0 : (idx == 2'd1) ? HT_MAX1 : HT_MAX2;
  endfunction

endpackage

// File: rtl/campo_wrap.sv
// One 8-bit edit field: range-checked load, wrapping increment/decrement.
module campo_wrap (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       inc,
  input  logic       dec,
  input  logic [7:0] load_val,
  input  logic [7:0] min_v,
  input  logic [7:0] max_v,
  output logic [7:0] q
);

  logic [7:0] q_q, q_d;

  // Range compares come before the add/sub so 8-bit wrap never shows.
  always_comb begin
    q_d = q_q;
    if (load)
      q_d = (load_val < min_v || load_val > max_v) ? min_v : load_val;
    else if (inc)
      q_d = (q_q >= max_v) ? min_v : q_q + 8'd1;
    else if (dec)
      q_d = (q_q <= min_v) ? max_v : q_q - 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/teclado_control.sv
// Key-pulse sequencer for hora/fecha/timer edit sessions with commit strobe.
// Optional edit-idle timeout is built when TECLADO_TIMEOUT_EN is defined.
module teclado_control
  import teclado_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       c,
  input  logic       t,
  input  logic       p,
  input  logic       enter,
  input  logic       arriba,
  input  logic       abajo,
  input  logic       izquierda,
  input  logic       derecha,
  input  logic [7:0] actual0,
  input  logic [7:0] actual1,
  input  logic [7:0] actual2,
  output logic       rx_en,
  output logic [1:0] modo,
  output logic [1:0] cursor,
  output logic [7:0] campo0,
  output logic [7:0] campo1,
  output logic [7:0] campo2,
  output logic       wr,
  output logic [1:0] wr_modo
);

  state_e          state_q, state_d;
  logic [1:0]      modo_q, modo_d;
  logic [1:0]      cursor_q, cursor_d;
  logic            ld;
  logic [2:0]      inc, dec;
  logic [1:0]      lim_modo;
  logic            to_hit;
  logic [2:0][7:0] act, campo_q;

  assign act = {actual2, actual1, actual0};

  always_comb begin
    state_d  = state_q;
    modo_d   = modo_q;
    cursor_d = cursor_q;
    ld       = 1'b0;
    inc      = '0;
    dec      = '0;
    unique case (state_q)
      IDLE: begin
        if (c)      modo_d = MODO_HORA;
        else if (t) modo_d = MODO_TIMER;
        else if (p) modo_d = MODO_FECHA;
        if (c || t || p) begin
          ld       = 1'b1;
          cursor_d = 2'd0;
          state_d  = EDIT;
        end
      end
      EDIT: begin
        if (enter)          state_d = COMMIT;
        else if (arriba)    inc = 3'b001 << cursor_q;
        else if (abajo)     dec = 3'b001 << cursor_q;
        else if (izquierda) cursor_d = (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
        else if (derecha)   cursor_d = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
        else if (to_hit) begin
          state_d  = IDLE;
          modo_d   = MODO_IDLE;
          cursor_d = 2'd0;
        end
      end
      COMMIT: begin
        state_d  = IDLE;
        modo_d   = MODO_IDLE;
        cursor_d = 2'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      modo_q   <= MODO_IDLE;
      cursor_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      modo_q   <= modo_d;
      cursor_q <= cursor_d;
    end
  end

`ifdef TECLADO_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        key_any;

  assign key_any = enter | arriba | abajo | izquierda | derecha;

  always_comb begin
    cnt_d  = '0;
    to_hit = 1'b0;
    if (state_q == EDIT && !key_any) begin
      cnt_d  = cnt_q + 32'd1;
      to_hit = (cnt_q == TIMEOUT_CYCLES - 32'd1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  // While loading, limits follow the mode being latched, not the idle one.
  assign lim_modo = (state_q == IDLE) ? modo_d : modo_q;

  for (genvar i = 0; i < 3; i++) begin : g_campo
    campo_wrap u_campo (
      .clk     (clk),
      .rst_n   (reset),
      .load    (ld),
      .inc     (inc[i]),
      .dec     (dec[i]),
      .load_val(act[i]),
      .min_v   (fld_min(lim_modo, 2'(i))),
      .max_v   (fld_max(lim_modo, 2'(i))),
      .q       (campo_q[i])
    );
  end

  assign campo0  = campo_q[0];
  assign campo1  = campo_q[1];
  assign campo2  = campo_q[2];
  assign modo    = modo_q;
  assign cursor  = cursor_q;
  assign wr      = (state_q == COMMIT);
  assign wr_modo = wr ? modo_q : MODO_IDLE;
  assign rx_en   = !wr;

endmodule
